input_conditioner: RTL
======================

Name: input_conditioner

Overview:
- Board-input front end: synchronises, debounces and edge-detects the push buttons and slide switches before they reach the computer ports and the clock/display selectors.
- Replaces the ad-hoc 100 Hz sampling of buttons and switches in the board top level.
- Outputs clean levels (for PORTI/PORTJ and the clock/display/test selects) and one-cycle press/release/change strobes (for single-step clocking and IRQ sources).
- Sits between the board pins and the comp instance; clocked from the 100 MHz board clock.

Parameters:
- NBTN, 5, number of push-button inputs.
- NSW, 16, number of slide-switch inputs.
- TICK_DIV, 100000, clk cycles per debounce sample tick (1 kHz at 100 MHz); minimum 2.
- DB_CNT, 10, consecutive differing ticks needed to accept a new level; minimum 1.

Ports:
- clk  in  1  system clock (100 MHz board clock).
- reset  in  1  asynchronous reset, active low.
- BTN_IN  in  NBTN  raw button pins, asynchronous.
- SW_IN  in  NSW  raw switch pins, asynchronous.
- btn_level  out  NBTN  debounced button levels.
- btn_press  out  NBTN  one-cycle strobe on debounced 0->1.
- btn_release  out  NBTN  one-cycle strobe on debounced 1->0.
- sw_level  out  NSW  debounced switch levels.
- sw_change  out  NSW  one-cycle strobe on any debounced switch transition.
- tick  out  1  debounce sample strobe, exposed for test/display.

Behaviour:
- Reset, asynchronous while reset==0:
  - all synchroniser flops, levels, debounce counters, prescaler and strobes clear to 0.
  - Operation starts on the first clk edge after reset deasserts.
- Synchroniser: 2 flops per input; the sampled value s is valid 2 clk edges after a pin change.
- Prescaler:
  - shared counter 0..TICK_DIV-1 that wraps to 0.
  - tick=1 for exactly one cycle when the count equals TICK_DIV-1; period is exactly TICK_DIV cycles.
- Debounce cell, per input, two states:
  - STABLE (cnt==0) and PENDING (cnt>0). State changes only in a tick cycle.
  - Tick with s==level: cnt <= 0 (any glitch restarts qualification); state STABLE.
  - Tick with s!=level and cnt<DB_CNT-1: cnt <= cnt+1; state PENDING.
  - Tick with s!=level and cnt==DB_CNT-1: level <= s, cnt <= 0, and the matching strobe is asserted for that single clk cycle.
  - Non-tick cycles: cnt and level hold; strobes are 0.
  - Counter width is clog2(DB_CNT) with a minimum of 1. When DB_CNT=1 the level follows s on the first differing tick.
- Latency from pin change to level change: 2 + [TICK_DIV*(DB_CNT-1)+1 .. TICK_DIV*DB_CNT] clk cycles.
- Strobes:
  - registered, asserted in the same cycle the level register updates.
  - btn_press and btn_release are never high together for the same bit.
  - sw_change = press OR release for that switch.
- Independence: every bit is independent. Simultaneous transitions on several inputs in the same tick produce simultaneous strobes.
- Power-up with switches already high: sw_level rises after the debounce latency and sw_change pulses once. Consumers must tolerate this.
- Reset mid-PENDING: the count is discarded. A held input re-qualifies from zero after reset release.

Decomposition:
- defs.v: default TICK_DIV and DB_CNT constants (COND_TICK_DIV, COND_DB_CNT) so the board tops share values.
- Sub-module debounce_cell: one input; contains synchroniser, counter, level and strobes; inputs tick.
- input_conditioner: the prescaler plus generate loops of NBTN+NSW debounce_cell instances.

Test Plan (bench parameters TICK_DIV=4, DB_CNT=3, NBTN=5, NSW=4):
- Reset, then all inputs held 0 for 40 cycles -> all outputs 0; tick pulses every 4th cycle.
- BTN_IN[0] 0->1 held -> btn_level[0] rises 11..14 cycles later; btn_press[0] high exactly 1 cycle; btn_release stays 0.
- BTN_IN[2] high for 6 cycles then low (glitch shorter than 3 ticks) -> btn_level[2], btn_press[2] and btn_release[2] stay 0.
- SW_IN=4'b1010 applied at once -> sw_level becomes 4'b1010 in one cycle; sw_change=4'b1010 for that one cycle; then SW_IN=0 -> sw_change=4'b1010 again.
- Button held high, reset pulsed low for 3 cycles after 2 ticks of PENDING -> outputs 0 during reset; btn_level rises 11..14 cycles after reset release, not earlier.
- All 5 buttons pressed together -> btn_press=5'b11111 in a single cycle; released together -> btn_release=5'b11111 in a single cycle.

Source files
------------

// File: rtl/input_conditioner_pkg.sv
// Shared constants and types for the board-input conditioner.
// Board tops import this package so they all agree on debounce timing.
package input_conditioner_pkg;

    // Default clk cycles per debounce sample tick (1 kHz at 100 MHz).
    localparam int unsigned COND_TICK_DIV = 100000;

    // Default number of consecutive differing ticks needed to accept a new level.
    localparam int unsigned COND_DB_CNT = 10;

    // Debounce cell state: STABLE while the count is zero, PENDING while qualifying.
    typedef enum logic {
        DB_STABLE  = 1'b0,
        DB_PENDING = 1'b1
    } db_state_t;

    // Qualification counter width: clog2(db_cnt), never narrower than one bit.
    function automatic int unsigned db_cnt_width(input int unsigned db_cnt);
        return (db_cnt <= 2) ? 1 : $clog2(db_cnt);
    endfunction

endpackage

// File: rtl/input_conditioner_debounce_cell.sv
// One conditioned input: two-flop synchroniser, tick-paced qualification
// counter, debounced level register and registered rise/fall strobes.
module input_conditioner_debounce_cell
    import input_conditioner_pkg::*;
#(
    parameter int unsigned DB_CNT = COND_DB_CNT
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int unsigned    CW       = db_cnt_width(DB_CNT);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CNT - 1);

    logic          sync_q1;
    logic          sync_q2;
    db_state_t     state_q;
    db_state_t     state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          level_d;
    logic          rise_d;
    logic          fall_d;

    // Bring the asynchronous pin into the clk domain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= pin;
            sync_q2 <= sync_q1;
        end
    end

    // Debounce state, count, level and strobe registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= DB_STABLE;
            cnt_q   <= '0;
            level   <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level   <= level_d;
            rise    <= rise_d;
            fall    <= fall_d;
        end
    end

    // Advance qualification only on ticks; any agreeing sample restarts it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (tick) begin
            if (sync_q2 == level) begin
                state_d = DB_STABLE;
                cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
                state_d = DB_STABLE;
                cnt_d   = '0;
                level_d = sync_q2;
                rise_d  = sync_q2;
                fall_d  = ~sync_q2;
            end else begin
                state_d = DB_PENDING;
                cnt_d   = cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// Board-input front end: shared debounce prescaler plus one debounce cell
// per push button and slide switch, giving clean levels and edge strobes.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int unsigned NBTN     = 5,
    parameter int unsigned NSW      = 16,
    parameter int unsigned TICK_DIV = COND_TICK_DIV,
    parameter int unsigned DB_CNT   = COND_DB_CNT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NBTN-1:0] BTN_IN,
    input  logic [NSW-1:0]  SW_IN,
    output logic [NBTN-1:0] btn_level,
    output logic [NBTN-1:0] btn_press,
    output logic [NBTN-1:0] btn_release,
    output logic [NSW-1:0]  sw_level,
    output logic [NSW-1:0]  sw_change,
    output logic            tick
);

    localparam int unsigned   PW      = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]  ps_q;
    logic [NSW-1:0] sw_rise;
    logic [NSW-1:0] sw_fall;

    // Free-running prescaler counting 0..TICK_DIV-1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ps_q <= '0;
        end else if (ps_q == PS_LAST) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_q + 1'b1;
        end
    end

    // One-cycle sample strobe on the last prescaler count.
    always_comb begin
        tick = (ps_q == PS_LAST);
    end

    for (genvar gb = 0; gb < NBTN; gb++) begin : g_btn
        input_conditioner_debounce_cell #(
            .DB_CNT (DB_CNT)
        ) u_cell (
            .clk   (clk),
            .reset (reset),
            .tick  (tick),
            .pin   (BTN_IN[gb]),
            .level (btn_level[gb]),
            .rise  (btn_press[gb]),
            .fall  (btn_release[gb])
        );
    end

    for (genvar gs = 0; gs < NSW; gs++) begin : g_sw
        input_conditioner_debounce_cell #(
            .DB_CNT (DB_CNT)
        ) u_cell (
            .clk   (clk),
            .reset (reset),
            .tick  (tick),
            .pin   (SW_IN[gs]),
            .level (sw_level[gs]),
            .rise  (sw_rise[gs]),
            .fall  (sw_fall[gs])
        );
    end

    // Switch consumers only care that a transition happened, not its direction.
    always_comb begin
        sw_change = sw_rise | sw_fall;
    end

endmodule
